uart_instr_loader: RTL and testbench
====================================

// Module: uart_instr_loader
// PURPOSE
//  UART receive front end for the instruction ROM loader. Samples the serial
//  line and deserializes 8N1 bytes. Packs byte pairs into 16-bit instruction
//  words and issues single-cycle write strobes into the instruction BRAM.
//  Declares the program load complete after an idle-line timeout. Sits
//  directly upstream of the instruction BRAM/ROM block, which consumes
//  o_wr_*, o_done and o_max_addr.
// PARAMETERS
//  CLK_FREQ       100_000_000  i_clk_uart frequency, Hz
//  BAUD           115200       line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (868)
//  ADDR_W         8            word address width (2**ADDR_W words)
//  IDLE_TO_BITS   32           idle bit-times after last byte that end the load
// PORTS
//  i_clk_uart    in   1       single clock for all logic
//  i_rst_n       in   1       reset; synchronous, active-low
//  i_rx          in   1       asynchronous UART line, idle high
//  o_byte_valid  out  1       1-cycle pulse, o_byte holds a good byte
//  o_byte        out  8       last received byte
//  o_frame_err   out  1       1-cycle pulse, stop bit sampled low
//  o_wr_en       out  1       1-cycle BRAM write strobe
//  o_wr_addr     out  ADDR_W  word write address
//  o_wr_data     out  16      {first byte, second byte}
//  o_done        out  1       sticky, load complete
//  o_max_addr    out  ADDR_W  address of the last word written
// BEHAVIOUR
//  Reset values
//  - All outputs reset to 0.
//  - RX synchronizer flops reset to 1.
//  - FSM reset state is IDLE; write pointer, phase and idle counter reset to 0.
//  - Reset mid-frame aborts the byte and any pending high byte.
//  Input and RX state machine
//  - i_rx passes through a 2-FF synchronizer; rx_s denotes the synchronized line.
//  - IDLE: rx_s==0 -> START, bit counter cleared.
//  - START: at count CLKS_PER_BIT/2, rx_s==0 -> DATA. Otherwise -> IDLE as a
//    glitch, with no pulse.
//  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
//  - STOP: sample after CLKS_PER_BIT cycles.
//    - If rx_s==1: o_byte_valid=1 and o_byte updated.
//    - If rx_s==0: o_frame_err=1 and the byte is discarded (phase unchanged).
//    - Either way -> IDLE the following cycle.
//  Packer
//  - phase=0: a valid byte is stored as the high byte and phase becomes 1.
//  - phase=1: on the cycle after o_byte_valid, o_wr_en=1 with
//    o_wr_addr=wr_ptr and o_wr_data={hi,byte}.
//    o_max_addr<=wr_ptr, wr_ptr++, phase<=0.
//  Full
//  - After the word at address 2**ADDR_W-1 is written, later words are dropped:
//    no o_wr_en, and o_max_addr holds.
//  Idle timeout
//  - The idle counter increments while FSM==IDLE, at least one valid byte has
//    been received, and o_done==0.
//  - Any START entry clears the counter.
//  - When it reaches IDLE_TO_BITS*CLKS_PER_BIT:
//    - If phase==1, first write {hi,8'h00}; that write has the same timing and
//      the same full-state rules as a normal write.
//    - Then o_done<=1 on the next cycle.
//  - With zero bytes received, o_done never asserts.
//  After o_done
//  - Bytes still pulse o_byte_valid and o_frame_err.
//  - They cause no writes; state holds until reset.
// TESTING  (CLKS_PER_BIT=868; 1 bit = 8680 ns)
//  1. Reset with i_rx=1 -> all outputs 0 for 100 cycles; no pulses.
//  2. Send A5,5A with 3-bit gaps -> o_byte_valid pulses with A5, then 5A. One
//     o_wr_en at addr 0, data 16'hA55A, one cycle after the second byte. No done.
//  3. Send A5,5A,3C then hold idle 32 bit-times -> writes 0:A55A and 1:3C00.
//     o_done=1 and o_max_addr=1.
//  4. Pulse i_rx low for 200 cycles -> no valid, no frame_err. Then byte 10
//     received correctly as the high byte.
//  5. Byte 10 with stop bit 0 -> o_frame_err pulse, no byte_valid, no write.
//     Next two good bytes 3C,2B -> write 0:3C2B.
//  6. ADDR_W=2, send 10 bytes 10..19 -> 4 writes at addr 0..3, then o_max_addr=3
//     and bytes 18,19 dropped. Separately, reset mid-DATA -> state cleared; the
//     next pair writes at addr 0.

Source files
------------

// File: rtl/uart_instr_loader_if.sv
// Serial line plus BRAM write / load-status bundle for the UART instruction loader.
interface uart_instr_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              i_rx;
  logic              o_byte_valid;
  logic [7:0]        o_byte;
  logic              o_frame_err;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [15:0]       o_wr_data;
  logic              o_done;
  logic [ADDR_W-1:0] o_max_addr;

  // Loader side: drives the write port and status, receives the line.
  modport master (
    input  i_rx,
    output o_byte_valid,
    output o_byte,
    output o_frame_err,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data,
    output o_done,
    output o_max_addr
  );

  // Consumer side: BRAM/ROM block plus whatever drives the line.
  modport slave (
    output i_rx,
    input  o_byte_valid,
    input  o_byte,
    input  o_frame_err,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data,
    input  o_done,
    input  o_max_addr
  );
endinterface

// File: rtl/uart_instr_loader.sv
// UART 8N1 receiver that packs byte pairs into 16-bit instruction words,
// writes them into the instruction BRAM and flags load completion after
// an idle-line timeout.
module uart_instr_loader #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned IDLE_TO_BITS = 32
) (
  input  logic                i_clk_uart,
  input  logic                i_rst_n,
  uart_instr_loader_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDLE_LIMIT   = IDLE_TO_BITS * CLKS_PER_BIT;
  localparam int unsigned IDLE_W       = $clog2(IDLE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Receiver state
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_q, byte_d;
  logic             frame_err_q, frame_err_d;

  // Packer / write-port / timeout state
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              full_q, full_d;
  logic              got_byte_q, got_byte_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              done_pend_q, done_pend_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d;

  // Packer scratch
  logic              accept;
  logic              flush;
  logic              start_entry;
  logic              do_write;
  logic [15:0]       wdata;

  // Receiver registers; synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk_uart) begin
    if (!i_rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Receiver next state: start qualification at mid-bit, LSB-first data, stop check.
  always_comb begin
    rx_meta_d    = bus.i_rx;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF_BIT)) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (rx_s_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shreg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Packer registers.
  always_ff @(posedge i_clk_uart) begin
    if (!i_rst_n) begin
      phase_q     <= 1'b0;
      hi_q        <= '0;
      wr_ptr_q    <= '0;
      full_q      <= 1'b0;
      got_byte_q  <= 1'b0;
      idle_cnt_q  <= '0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      max_addr_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      wr_ptr_q    <= wr_ptr_d;
      full_q      <= full_d;
      got_byte_q  <= got_byte_d;
      idle_cnt_q  <= idle_cnt_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      max_addr_q  <= max_addr_d;
    end
  end

  // Pair bytes into words, flush a dangling high byte on timeout, then latch done.
  always_comb begin
    phase_d     = phase_q;
    hi_d        = hi_q;
    wr_ptr_d    = wr_ptr_q;
    full_d      = full_q;
    got_byte_d  = got_byte_q | byte_valid_q;
    idle_cnt_d  = idle_cnt_q;
    done_pend_d = done_pend_q;
    done_d      = done_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    max_addr_d  = max_addr_q;
    do_write    = 1'b0;
    wdata       = '0;

    accept      = byte_valid_q && !done_q && !done_pend_q;
    start_entry = (state_q == S_IDLE) && (state_d == S_START);
    flush       = (state_q == S_IDLE) && got_byte_q && !done_q && !done_pend_q &&
                  (idle_cnt_q == IDLE_W'(IDLE_LIMIT));

    // Idle-line timer: only armed once something has been received.
    if (start_entry) begin
      idle_cnt_d = '0;
    end else if ((state_q == S_IDLE) && got_byte_q && !done_q &&
                 (idle_cnt_q != IDLE_W'(IDLE_LIMIT))) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    if (accept) begin
      if (!phase_q) begin
        hi_d    = byte_q;
        phase_d = 1'b1;
      end else begin
        phase_d  = 1'b0;
        do_write = 1'b1;
        wdata    = {hi_q, byte_q};
      end
    end else if (flush) begin
      done_pend_d = 1'b1;
      if (phase_q) begin
        phase_d  = 1'b0;
        do_write = 1'b1;
        wdata    = {hi_q, 8'h00};
      end
    end

    if (done_pend_q) begin
      done_pend_d = 1'b0;
      done_d      = 1'b1;
    end

    // Once the top address has been written the memory is full; extra words vanish.
    if (do_write && !full_q) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = wr_ptr_q;
      wr_data_d  = wdata;
      max_addr_d = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
      if (wr_ptr_q == {ADDR_W{1'b1}}) begin
        full_d = 1'b1;
      end
    end
  end

  // Registered outputs.
  assign bus.o_byte_valid = byte_valid_q;
  assign bus.o_byte       = byte_q;
  assign bus.o_frame_err  = frame_err_q;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_done       = done_q;
  assign bus.o_max_addr   = max_addr_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Bench for uart_instr_loader: table of frames with expected pulses/writes fed
// into a scoreboard, plus sequences for timeout flush, full memory and reset.
module tb_uart_instr_loader;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CPB    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_instr_loader #(
    .CLK_FREQ    (1_600_000),
    .BAUD        (100_000),
    .ADDR_W      (ADDR_W),
    .IDLE_TO_BITS(32)
  ) dut (
    .i_clk_uart(clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    bit                flush;
  } wr_exp_t;

  typedef struct {
    bit                glitch;
    logic [7:0]        data;
    bit                stop;
    bit                exp_valid;
    bit                exp_ferr;
    bit                exp_wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] exp_max;
  } vec_t;

  logic [7:0] byte_exp_q[$];
  wr_exp_t    wr_exp_q[$];
  int         ferr_exp;
  int         errors;
  int         checks;
  longint     cyc;
  longint     last_valid_cyc;
  vec_t       vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input bit g, input logic [7:0] d, input bit s, input bit v,
                              input bit fe, input bit w, input logic [ADDR_W-1:0] a,
                              input logic [15:0] wd, input logic [ADDR_W-1:0] mx);
    vec_t r;
    r.glitch = g; r.data = d; r.stop = s; r.exp_valid = v; r.exp_ferr = fe;
    r.exp_wr = w; r.wr_addr = a; r.wr_data = wd; r.exp_max = mx;
    return r;
  endfunction

  // Scoreboard: every output pulse must match the next expectation in order.
  always @(negedge clk) begin
    cyc++;
    if (bus.o_byte_valid) begin
      if (byte_exp_q.size() == 0) begin
        check("byte_unexpected", 32'(bus.o_byte_valid), 32'd0);
      end else begin
        check("byte_value", 32'(bus.o_byte), 32'(byte_exp_q.pop_front()));
      end
      last_valid_cyc = cyc;
    end
    if (bus.o_wr_en) begin
      if (wr_exp_q.size() == 0) begin
        check("wr_unexpected", 32'(bus.o_wr_en), 32'd0);
      end else begin
        wr_exp_t e;
        e = wr_exp_q.pop_front();
        check("wr_addr", 32'(bus.o_wr_addr), 32'(e.addr));
        check("wr_data", 32'(bus.o_wr_data), 32'(e.data));
        if (!e.flush) check("wr_latency", 32'(cyc - last_valid_cyc), 32'd1);
      end
    end
    if (bus.o_frame_err) begin
      check("ferr_expected", 32'(bus.o_frame_err), 32'(ferr_exp > 0));
      if (ferr_exp > 0) ferr_exp--;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int gap_bits);
    bus.i_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.i_rx = b[i];
      wait_clks(CPB);
    end
    bus.i_rx = stop;
    wait_clks(CPB);
    bus.i_rx = 1'b1;
    wait_clks(gap_bits * CPB);
  endtask

  task automatic glitch();
    bus.i_rx = 1'b0;
    wait_clks(5);
    bus.i_rx = 1'b1;
    wait_clks(3 * CPB);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.i_rx = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(2);
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d, input bit fl);
    wr_exp_t e;
    e.addr = a; e.data = d; e.flush = fl;
    wr_exp_q.push_back(e);
  endtask

  // Bound on total run time.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] acc;
    errors = 0; checks = 0; ferr_exp = 0; cyc = 0; last_valid_cyc = 0;
    bus.i_rx = 1'b1;

    vecs[0] = mk(0, 8'hA5, 1, 1, 0, 0, 2'd0, 16'h0000, 2'd0);
    vecs[1] = mk(0, 8'h5A, 1, 1, 0, 1, 2'd0, 16'hA55A, 2'd0);
    vecs[2] = mk(1, 8'h00, 1, 0, 0, 0, 2'd0, 16'h0000, 2'd0);
    vecs[3] = mk(0, 8'h10, 0, 0, 1, 0, 2'd0, 16'h0000, 2'd0);
    vecs[4] = mk(0, 8'h3C, 1, 1, 0, 0, 2'd0, 16'h0000, 2'd0);
    vecs[5] = mk(0, 8'h2B, 1, 1, 0, 1, 2'd1, 16'h3C2B, 2'd1);
    vecs[6] = mk(1, 8'h00, 1, 0, 0, 0, 2'd0, 16'h0000, 2'd1);
    vecs[7] = mk(0, 8'h10, 1, 1, 0, 0, 2'd0, 16'h0000, 2'd1);
    vecs[8] = mk(0, 8'h77, 1, 1, 0, 1, 2'd2, 16'h1077, 2'd2);

    // Reset and quiet line: every output stays zero.
    do_reset();
    acc = '0;
    for (int i = 0; i < 100; i++) begin
      acc = acc | 32'({bus.o_byte_valid, bus.o_byte, bus.o_frame_err, bus.o_wr_en,
                       bus.o_wr_addr, bus.o_wr_data, bus.o_done, bus.o_max_addr});
      @(negedge clk);
    end
    check("reset_outputs_zero", acc, 32'd0);
    // No bytes ever received: no done even after a long idle line.
    wait_clks(40 * CPB);
    check("no_bytes_no_done", 32'(bus.o_done), 32'd0);

    // Table of frames.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].exp_valid) byte_exp_q.push_back(vecs[i].data);
      if (vecs[i].exp_ferr) ferr_exp++;
      if (vecs[i].exp_wr) push_wr(vecs[i].wr_addr, vecs[i].wr_data, 1'b0);
      if (vecs[i].glitch) glitch();
      else send_frame(vecs[i].data, vecs[i].stop, 3);
      check($sformatf("row%0d_done", i), 32'(bus.o_done), 32'd0);
      check($sformatf("row%0d_max_addr", i), 32'(bus.o_max_addr), 32'(vecs[i].exp_max));
      check($sformatf("row%0d_ferr_consumed", i), 32'(ferr_exp), 32'd0);
    end

    // Dangling high byte flushed with low byte 00 on timeout, then done.
    byte_exp_q.push_back(8'h3C);
    push_wr(2'd3, 16'h3C00, 1'b1);
    send_frame(8'h3C, 1'b1, 0);
    check("flush_not_done_yet", 32'(bus.o_done), 32'd0);
    wait_clks(40 * CPB);
    check("flush_done", 32'(bus.o_done), 32'd1);
    check("flush_max_addr", 32'(bus.o_max_addr), 32'd3);
    check("flush_write_seen", 32'(wr_exp_q.size()), 32'd0);

    // After done: pulses continue, no writes, state holds.
    byte_exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 2);
    ferr_exp++;
    send_frame(8'h66, 1'b0, 2);
    byte_exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 2);
    check("post_done_sticky", 32'(bus.o_done), 32'd1);
    check("post_done_max_addr", 32'(bus.o_max_addr), 32'd3);

    // Full memory: ten bytes, only four words land.
    do_reset();
    check("rst_clears_done", 32'(bus.o_done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(i);
      byte_exp_q.push_back(b);
      if ((i % 2 == 1) && (i < 8)) push_wr(2'(i / 2), {b - 8'd1, b}, 1'b0);
      send_frame(b, 1'b1, 2);
    end
    check("full_max_addr", 32'(bus.o_max_addr), 32'd3);
    check("full_not_done", 32'(bus.o_done), 32'd0);
    wait_clks(40 * CPB);
    check("full_done", 32'(bus.o_done), 32'd1);
    check("full_max_addr_hold", 32'(bus.o_max_addr), 32'd3);

    // Reset mid-DATA discards both the partial frame and a pending high byte.
    do_reset();
    byte_exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1, 2);
    bus.i_rx = 1'b0;
    wait_clks(CPB);
    bus.i_rx = 1'b1; wait_clks(CPB);
    bus.i_rx = 1'b0; wait_clks(CPB);
    bus.i_rx = 1'b1; wait_clks(CPB / 2);
    rst_n = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(3 * CPB);
    check("midrst_max_addr", 32'(bus.o_max_addr), 32'd0);
    check("midrst_done", 32'(bus.o_done), 32'd0);
    byte_exp_q.push_back(8'h3C);
    byte_exp_q.push_back(8'h2B);
    push_wr(2'd0, 16'h3C2B, 1'b0);
    send_frame(8'h3C, 1'b1, 2);
    send_frame(8'h2B, 1'b1, 2);
    check("midrst_pair_max_addr", 32'(bus.o_max_addr), 32'd0);

    wait_clks(10);
    check("byte_queue_empty", 32'(byte_exp_q.size()), 32'd0);
    check("wr_queue_empty", 32'(wr_exp_q.size()), 32'd0);
    check("ferr_all_seen", 32'(ferr_exp), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
